// File: rtl/reorder_queue_pkg.sv
// Shared kind encodings and default widths for the in-order commit reorder queue.
package reorder_queue_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_REG_INDEX = 5;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_WB_PORTS  = 2;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_HALT   = 2'd3
    } kind_e;

endpackage

// File: rtl/reorder_queue.sv
// Reorder queue: in-order allocation, out-of-order writeback, in-order commit
// of register writes, stores, branch flushes and halt.
module reorder_queue
    import reorder_queue_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int REG_INDEX = DEF_REG_INDEX,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WB_PORTS  = DEF_WB_PORTS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [1:0]                        alloc_kind,
    input  logic [REG_INDEX-1:0]              alloc_rdest,
    output logic [$clog2(DEPTH)-1:0]          alloc_idx,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*$clog2(DEPTH)-1:0] wb_idx,
    input  logic [WB_PORTS*WORD_SIZE-1:0]     wb_data,
    input  logic [WB_PORTS*WORD_SIZE-1:0]     wb_addr,
    input  logic [WB_PORTS-1:0]               wb_mispredict,
    output logic                              reg_we,
    output logic [REG_INDEX-1:0]              reg_waddr,
    output logic [WORD_SIZE-1:0]              reg_wdata,
    output logic [$clog2(DEPTH)-1:0]          commit_idx,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic [WORD_SIZE-1:0]              mem_addr,
    output logic [WORD_SIZE-1:0]              mem_wdata,
    output logic                              flush_valid,
    output logic [WORD_SIZE-1:0]              flush_pc,
    output logic                              halted,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int IDX = $clog2(DEPTH);
    localparam logic [IDX:0] PTR_ONE  = (IDX+1)'(1);
    localparam logic [IDX:0] FULL_CNT = (IDX+1)'(DEPTH);

    logic [IDX:0] head_q, head_d;
    logic [IDX:0] tail_q, tail_d;
    logic [IDX:0] count_q, count_d;
    logic         halted_q, halted_d;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] misp_q, misp_d;

    kind_e                kind_q  [DEPTH];
    kind_e                kind_d  [DEPTH];
    logic [REG_INDEX-1:0] rdest_q [DEPTH];
    logic [REG_INDEX-1:0] rdest_d [DEPTH];
    logic [WORD_SIZE-1:0] data_q  [DEPTH];
    logic [WORD_SIZE-1:0] data_d  [DEPTH];
    logic [WORD_SIZE-1:0] addr_q  [DEPTH];
    logic [WORD_SIZE-1:0] addr_d  [DEPTH];

    logic [IDX-1:0] hidx;
    logic [IDX-1:0] tidx;
    logic [IDX-1:0] widx;
    kind_e          hkind;
    logic           empty;
    logic           full;
    logic           head_ok;
    logic           flush_now;
    logic           alloc_fire;
    logic           commit_fire;

    always_comb begin
        hidx        = head_q[IDX-1:0];
        tidx        = tail_q[IDX-1:0];
        hkind       = kind_q[hidx];
        empty       = (head_q == tail_q);
        full        = (count_q == FULL_CNT);
        head_ok     = !empty && !halted_q && valid_q[hidx] && done_q[hidx];
        flush_now   = head_ok && (hkind == KIND_BRANCH) && misp_q[hidx];
        alloc_ready = !full && !halted_q && !flush_now;
        alloc_fire  = alloc_valid && alloc_ready;
        // Stores hold the head until the memory side accepts them.
        commit_fire = head_ok && ((hkind != KIND_STORE) || mem_ready);

        alloc_idx   = tidx;
        commit_idx  = hidx;
        count       = count_q;
        halted      = halted_q;

        reg_we      = head_ok && (hkind == KIND_REG);
        reg_waddr   = reg_we ? rdest_q[hidx] : '0;
        reg_wdata   = reg_we ? data_q[hidx] : '0;

        mem_valid   = head_ok && (hkind == KIND_STORE);
        mem_addr    = mem_valid ? addr_q[hidx] : '0;
        mem_wdata   = mem_valid ? data_q[hidx] : '0;

        flush_valid = flush_now;
        flush_pc    = flush_now ? addr_q[hidx] : '0;
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        halted_d = halted_q;
        valid_d  = valid_q;
        done_d   = done_q;
        misp_d   = misp_q;
        kind_d   = kind_q;
        rdest_d  = rdest_q;
        data_d   = data_q;
        addr_d   = addr_q;
        widx     = '0;

        // Walk ports high to low so the lowest port lands last and wins.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            widx = wb_idx[p*IDX +: IDX];
            if (wb_valid[p] && valid_q[widx] && !flush_now) begin
                done_d[widx] = 1'b1;
                misp_d[widx] = wb_mispredict[p];
                data_d[widx] = wb_data[p*WORD_SIZE +: WORD_SIZE];
                addr_d[widx] = wb_addr[p*WORD_SIZE +: WORD_SIZE];
            end
        end

        if (commit_fire) begin
            valid_d[hidx] = 1'b0;
            done_d[hidx]  = 1'b0;
            head_d        = head_q + PTR_ONE;
            if (hkind == KIND_HALT) begin
                halted_d = 1'b1;
            end
        end

        if (flush_now) begin
            valid_d = '0;
            done_d  = '0;
            tail_d  = head_q + PTR_ONE;
        end

        if (alloc_fire) begin
            valid_d[tidx] = 1'b1;
            done_d[tidx]  = (kind_e'(alloc_kind) == KIND_HALT);
            misp_d[tidx]  = 1'b0;
            kind_d[tidx]  = kind_e'(alloc_kind);
            rdest_d[tidx] = alloc_rdest;
            tail_d        = tail_q + PTR_ONE;
        end

        unique case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        if (flush_now) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            valid_q  <= '0;
            done_q   <= '0;
            misp_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kind_q[i]  <= KIND_REG;
                rdest_q[i] <= '0;
                data_q[i]  <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            misp_q   <= misp_d;
            kind_q   <= kind_d;
            rdest_q  <= rdest_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_reorder_queue.sv
// Self-checking bench for reorder_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_reorder_queue;
    import reorder_queue_pkg::*;

    localparam int W     = 32;
    localparam int RI    = 5;
    localparam int DEPTH = 8;
    localparam int WBP   = 2;
    localparam int IDX   = 3;

    logic             clk;
    logic             reset;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [1:0]       alloc_kind;
    logic [RI-1:0]    alloc_rdest;
    logic [IDX-1:0]   alloc_idx;
    logic [WBP-1:0]   wb_valid;
    logic [WBP*IDX-1:0] wb_idx;
    logic [WBP*W-1:0] wb_data;
    logic [WBP*W-1:0] wb_addr;
    logic [WBP-1:0]   wb_mispredict;
    logic             reg_we;
    logic [RI-1:0]    reg_waddr;
    logic [W-1:0]     reg_wdata;
    logic [IDX-1:0]   commit_idx;
    logic             mem_valid;
    logic             mem_ready;
    logic [W-1:0]     mem_addr;
    logic [W-1:0]     mem_wdata;
    logic             flush_valid;
    logic [W-1:0]     flush_pc;
    logic             halted;
    logic [IDX:0]     count;

    reorder_queue #(
        .WORD_SIZE(W), .REG_INDEX(RI), .DEPTH(DEPTH), .WB_PORTS(WBP)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_kind(alloc_kind), .alloc_rdest(alloc_rdest),
        .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_mispredict(wb_mispredict),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .commit_idx(commit_idx),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .halted(halted), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    kind;
        logic [RI-1:0] rdest;
        bit            done;
        bit            misp;
        logic [W-1:0]  data;
        logic [W-1:0]  addr;
        int            idx;
    } ent_t;

    ent_t q[$];
    int   head_seq;
    int   tail_seq;
    bit   m_halted;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_kind    = 2'd0;
        alloc_rdest   = '0;
        wb_valid      = '0;
        wb_idx        = '0;
        wb_data       = '0;
        wb_addr       = '0;
        wb_mispredict = '0;
        mem_ready     = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [RI-1:0] rd);
        alloc_valid = 1'b1;
        alloc_kind  = k;
        alloc_rdest = rd;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [W-1:0] d,
                          input logic [W-1:0] a, input bit m);
        wb_valid[p]            = 1'b1;
        wb_idx[p*IDX +: IDX]   = IDX'(idx);
        wb_data[p*W +: W]      = d;
        wb_addr[p*W +: W]      = a;
        wb_mispredict[p]       = m;
    endtask

    function automatic bit m_head_ok();
        return (q.size() > 0) && !m_halted && q[0].done;
    endfunction

    function automatic bit m_flush();
        return m_head_ok() && (q[0].kind == KIND_BRANCH) && q[0].misp;
    endfunction

    task automatic check_outputs();
        bit   h;
        bit   er;
        bit   em;
        bit   fl;
        ent_t e;
        h  = m_head_ok();
        e  = '{kind: 2'd0, rdest: '0, done: 1'b0, misp: 1'b0,
               data: '0, addr: '0, idx: 0};
        if (q.size() > 0) e = q[0];
        er = h && (e.kind == KIND_REG);
        em = h && (e.kind == KIND_STORE);
        fl = m_flush();
        chk("alloc_ready", alloc_ready,
            (q.size() < DEPTH) && !m_halted && !fl);
        chk("alloc_idx", alloc_idx, tail_seq % DEPTH);
        chk("count", count, q.size());
        chk("commit_idx", commit_idx, head_seq % DEPTH);
        chk("reg_we", reg_we, er);
        chk("reg_waddr", reg_waddr, er ? e.rdest : '0);
        chk("reg_wdata", reg_wdata, er ? e.data : '0);
        chk("mem_valid", mem_valid, em);
        chk("mem_addr", mem_addr, em ? e.addr : '0);
        chk("mem_wdata", mem_wdata, em ? e.data : '0);
        chk("flush_valid", flush_valid, fl);
        chk("flush_pc", flush_pc, fl ? e.addr : '0);
        chk("halted", halted, m_halted);
    endtask

    task automatic model_edge();
        bit         h;
        bit         fl;
        bit         rdy;
        bit [DEPTH-1:0] seen;
        logic [1:0] k;
        ent_t       e;
        int         wi;
        h    = m_head_ok();
        fl   = m_flush();
        rdy  = (q.size() < DEPTH) && !m_halted && !fl;
        seen = '0;
        if (!fl) begin
            for (int p = 0; p < WBP; p++) begin
                wi = int'(wb_idx[p*IDX +: IDX]);
                if (wb_valid[p] && !seen[wi]) begin
                    seen[wi] = 1'b1;
                    for (int j = 0; j < q.size(); j++) begin
                        if (q[j].idx == wi) begin
                            e      = q[j];
                            e.done = 1'b1;
                            e.misp = wb_mispredict[p];
                            e.data = wb_data[p*W +: W];
                            e.addr = wb_addr[p*W +: W];
                            q[j]   = e;
                        end
                    end
                end
            end
        end
        if (h && ((q[0].kind != KIND_STORE) || mem_ready)) begin
            k = q[0].kind;
            void'(q.pop_front());
            head_seq++;
            if (k == KIND_HALT) m_halted = 1'b1;
        end
        if (fl) begin
            q.delete();
            tail_seq = head_seq;
        end
        if (alloc_valid && rdy) begin
            e.kind  = alloc_kind;
            e.rdest = alloc_rdest;
            e.done  = (alloc_kind == KIND_HALT);
            e.misp  = 1'b0;
            e.data  = '0;
            e.addr  = '0;
            e.idx   = tail_seq % DEPTH;
            q.push_back(e);
            tail_seq++;
        end
    endtask

    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    task automatic m_clear();
        q.delete();
        head_seq = 0;
        tail_seq = 0;
        m_halted = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_flush", flush_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int  halt_wait;
    int  r;

    initial begin
        tests = 0;
        fails = 0;
        idle();
        m_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b1;

        // fill to capacity, then one blocked attempt
        for (int i = 0; i < 8; i++) begin
            alloc(KIND_REG, RI'(i + 1));
            cyc();
        end
        chk("fill_ready", alloc_ready, 1'b0);
        chk("fill_count", count, 8);
        alloc(KIND_REG, 5'd20);
        cyc();
        chk("fill_count_hold", count, 8);

        // out-of-order completion 2,1,0
        set_wb(0, 2, 32'h22, 0, 0);
        cyc();
        set_wb(0, 1, 32'h11, 0, 0);
        cyc();
        chk("ooo_no_we", reg_we, 1'b0);
        set_wb(0, 0, 32'h10, 0, 0);
        cyc();
        chk("ooo_we0", reg_we, 1'b1);
        chk("ooo_idx0", commit_idx, 0);
        chk("ooo_data0", reg_wdata, 32'h10);
        cyc();
        chk("ooo_idx1", commit_idx, 1);
        cyc();
        chk("ooo_idx2", commit_idx, 2);
        for (int i = 3; i < 8; i++) begin
            set_wb(1, i, $urandom, 0, 0);
            cyc();
        end
        repeat (3) cyc();
        chk("ooo_drained", count, 0);

        // store stall
        do_reset();
        alloc(KIND_STORE, 0);
        cyc();
        set_wb(0, 0, 32'hdead_beef, 32'h100, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_valid", mem_valid, 1'b1);
            chk("st_hold_addr", mem_addr, 32'h100);
            mem_ready = 1'b0;
            cyc();
        end
        chk("st_last_valid", mem_valid, 1'b1);
        mem_ready = 1'b1;
        cyc();
        chk("st_count", count, 0);
        chk("st_head", commit_idx, 1);

        // mispredict flush
        do_reset();
        alloc(KIND_REG, 5'd1);    cyc();
        alloc(KIND_BRANCH, 5'd0); cyc();
        alloc(KIND_REG, 5'd2);    cyc();
        alloc(KIND_REG, 5'd3);    cyc();
        alloc(KIND_REG, 5'd4);    cyc();
        set_wb(0, 2, 32'h2, 0, 0);
        set_wb(1, 3, 32'h3, 0, 0);
        cyc();
        set_wb(0, 4, 32'h4, 0, 0);
        set_wb(1, 1, 0, 32'h40, 1);
        cyc();
        set_wb(0, 0, 32'h7, 0, 0);
        cyc();
        cyc();
        chk("mp_flush", flush_valid, 1'b1);
        chk("mp_pc", flush_pc, 32'h40);
        chk("mp_ready", alloc_ready, 1'b0);
        alloc(KIND_REG, 5'd9);
        set_wb(0, 2, 32'h99, 0, 0);
        cyc();
        chk("mp_count", count, 0);
        chk("mp_no_flush", flush_valid, 1'b0);
        repeat (3) cyc();
        chk("mp_no_commit", reg_we, 1'b0);

        // port collision
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(KIND_REG, RI'(i + 8));
            cyc();
        end
        set_wb(0, 3, 32'd5, 0, 0);
        set_wb(1, 3, 32'd9, 0, 0);
        cyc();
        set_wb(0, 0, 32'd1, 0, 0);
        set_wb(1, 1, 32'd2, 0, 0);
        cyc();
        set_wb(0, 2, 32'd3, 0, 0);
        cyc();
        cyc();
        cyc();
        chk("col_idx", commit_idx, 3);
        chk("col_we", reg_we, 1'b1);
        chk("col_data", reg_wdata, 32'd5);
        cyc();

        // wrap then reset mid-store
        do_reset();
        for (int i = 0; i < 12; i++) begin
            alloc(KIND_REG, RI'(i));
            cyc();
            set_wb(0, i % DEPTH, $urandom, 0, 0);
            cyc();
            chk("wrap_we", reg_we, 1'b1);
            chk("wrap_idx", commit_idx, i % DEPTH);
            cyc();
        end
        alloc(KIND_STORE, 0);
        cyc();
        set_wb(0, 4, 32'h55, 32'h200, 0);
        cyc();
        chk("wrap_st_valid", mem_valid, 1'b1);
        do_reset();
        check_outputs();

        // random traffic
        halt_wait = 0;
        for (int n = 0; n < 600; n++) begin
            if (m_halted) halt_wait++;
            if (halt_wait > 4) begin
                do_reset();
                halt_wait = 0;
            end
            alloc_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 59);
            alloc_kind  = (r == 0) ? KIND_HALT :
                          (r < 12) ? KIND_BRANCH :
                          (r < 24) ? KIND_STORE : KIND_REG;
            alloc_rdest = RI'($urandom);
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(0, 9) < 6) begin
                    if (q.size() > 0 && $urandom_range(0, 4) != 0)
                        r = q[$urandom_range(0, q.size() - 1)].idx;
                    else
                        r = $urandom_range(0, DEPTH - 1);
                    set_wb(p, r, $urandom, $urandom,
                           $urandom_range(0, 5) == 0);
                end
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reorder_queue.md
REORDER_QUEUE -- requirements
Module: reorder_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning): WORD_SIZE, 32, data/address width.
REQ-002 SHALL have parameter REG_INDEX, 5, destination-register index width.
REQ-003 SHALL have parameter DEPTH, 8, number of entries (power of 2, >=4); IDX = log2(DEPTH).
REQ-004 SHALL have parameter WB_PORTS, 2, number of completion ports.
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, the single clock; reset, in, 1, asynchronous, active-low reset.
REQ-006 SHALL have alloc_valid, in, 1; alloc_ready, out, 1; alloc_kind, in, 2, REG/STORE/BRANCH/HALT; alloc_rdest, in, REG_INDEX; alloc_idx, out, IDX, entry assigned.
REQ-007 SHALL have wb_valid, in, WB_PORTS; wb_idx, in, WB_PORTS*IDX; wb_data and wb_addr, in, WB_PORTS*WORD_SIZE; wb_mispredict, in, WB_PORTS.
REQ-008 SHALL have reg_we, out, 1; reg_waddr, out, REG_INDEX; reg_wdata, out, WORD_SIZE; commit_idx, out, IDX, for clearing rename status.
REQ-009 SHALL have mem_valid, out, 1; mem_ready, in, 1; mem_addr and mem_wdata, out, WORD_SIZE.
REQ-010 SHALL have flush_valid, out, 1; flush_pc, out, WORD_SIZE; halted, out, 1; count, out, IDX+1.

Function
REQ-011 SHALL keep head/tail pointers with an extra wrap bit; empty when equal, full when count==DEPTH; indices wrap modulo DEPTH.
REQ-012 SHALL set alloc_ready = !full && !halted && !flush_now, using registered count; no alloc on a full cycle even if a commit also occurs.
REQ-013 SHALL, on alloc_valid&&alloc_ready, write the entry at tail (kind, rdest, done=0, mispredict=0), drive alloc_idx=tail combinationally, and advance tail next cycle.
REQ-014 SHALL, on wb_valid[p], mark entry wb_idx[p] done and store data, addr, mispredict; writes to non-allocated entries SHALL be ignored.
REQ-015 SHALL resolve same-cycle writebacks to one index so that the lowest port wins.
REQ-016 SHALL commit at most one entry per cycle, in order, from head, only when that entry is done; the earliest commit is the cycle after its writeback.
REQ-017 REG commit SHALL pulse reg_we for one cycle with reg_waddr=rdest, reg_wdata=data, commit_idx=head.
REQ-018 STORE commit SHALL assert mem_valid with addr/data held stable until mem_ready; head SHALL advance only on the mem_valid&&mem_ready cycle.
REQ-019 BRANCH commit without mispredict SHALL retire silently.
REQ-020 BRANCH commit with mispredict SHALL pulse flush_valid for one cycle with flush_pc=addr and SHALL invalidate all younger entries (tail:=head+1, count:=0 next cycle); alloc SHALL be blocked that cycle (flush_now).
REQ-021 Writebacks arriving in the flush cycle SHALL be discarded.
REQ-022 HALT commit SHALL set halted sticky until reset; no further alloc or commit.
REQ-023 Simultaneous alloc and commit SHALL leave count unchanged; count SHALL never exceed DEPTH nor go below 0.
REQ-024 A HALT entry SHALL be allocated already done.

Reset
REQ-025 Reset low SHALL asynchronously clear head, tail, count, all valid/done bits, halted, reg_we, mem_valid and flush_valid; data outputs SHALL reset to 0.
REQ-026 Reset mid-store SHALL drop mem_valid immediately; the store is lost.

Structure
REQ-027 Kind encodings (REG=0, STORE=1, BRANCH=2, HALT=3) and default widths SHALL live in the shared parameters package; entry storage and pointers SHALL be local.
REQ-028 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-029 Fill: 8 REG allocs, no wb -> alloc_ready=0 after the 8th, count=8.
REQ-030 Out-of-order completion: wb idx 2, 1, 0 on successive cycles -> reg_we on idx 0, 1, 2 in order, starting the cycle after idx 0 completes.
REQ-031 Store stall: STORE done at head, mem_ready low 3 cycles -> mem_valid held 4 cycles, head advances once.
REQ-032 Mispredict: BRANCH idx 1 mispredict, addr=0x40, idx 2-4 done -> flush_valid=1, flush_pc=0x40, idx 2-4 never commit, count=0.
REQ-033 Port collision: both ports wb idx 3, data 5 and 9 -> commit writes 5.
REQ-034 Wrap plus reset: 12 alloc/commit pairs with DEPTH=8, then reset low mid-store -> indices wrap 7->0 correctly; after reset count=0 and mem_valid=0.
